// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Keeps a shadow of EX/MEM/WB register usage to drive stalls, bubbles, squashes and forwarding.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] id_instr_i,
   input  logic        id_valid_i,
   input  logic        redirect_i,
   input  logic        mem_stall_i,
   output logic        stall_pc_o,
   output logic        stall_ifid_o,
   output logic        flush_ifid_o,
   output logic        bubble_ex_o,
   output logic        freeze_o,
   output logic [1:0]  fwd_a_o,
   output logic [1:0]  fwd_b_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IM    = 7'b0010011;
   localparam logic [6:0] OP_R     = 7'b0110011;

   logic [4:0]  ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
   logic        ex_u1_q, ex_u1_d, ex_u2_q, ex_u2_d, ex_we_q, ex_we_d, ex_ld_q, ex_ld_d;
   logic [4:0]  mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
   logic        mem_we_q, mem_we_d, wb_we_q, wb_we_d;
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic [6:0]  opcode;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_u1, id_u2, id_we, id_ld;
   logic        lu;
   logic        unused_bits;

   assign opcode      = id_instr_i[6:0];
   assign id_rs1      = id_instr_i[19:15];
   assign id_rs2      = id_instr_i[24:20];
   assign id_rd       = id_instr_i[11:7];
   assign unused_bits = ^{id_instr_i[31:25], id_instr_i[14:12]};

   always_comb begin
      id_u1 = 1'b0;
      id_u2 = 1'b0;
      id_we = 1'b0;
      id_ld = 1'b0;
      if (id_valid_i) begin
         id_u1 = (opcode == OP_JALR) || (opcode == OP_BR) || (opcode == OP_LD) ||
                 (opcode == OP_ST) || (opcode == OP_IM) || (opcode == OP_R);
         id_u2 = (opcode == OP_BR) || (opcode == OP_ST) || (opcode == OP_R);
         // x0 is never a real destination, so it can neither hazard nor forward
         id_we = ((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                  (opcode == OP_JALR) || (opcode == OP_LD) || (opcode == OP_IM) ||
                  (opcode == OP_R)) && (id_rd != 5'd0);
         id_ld = (opcode == OP_LD);
      end
   end

   assign lu = ex_ld_q && ex_we_q &&
               ((id_u1 && (id_rs1 == ex_rd_q)) || (id_u2 && (id_rs2 == ex_rd_q)));

   always_comb begin
      stall_pc_o   = 1'b0;
      stall_ifid_o = 1'b0;
      flush_ifid_o = 1'b0;
      bubble_ex_o  = 1'b0;
      freeze_o     = 1'b0;
      fwd_a_o      = 2'b00;
      fwd_b_o      = 2'b00;
      stall_cnt_o  = 32'd0;
      flush_cnt_o  = 32'd0;
      if (!rst) begin
         stall_cnt_o = stall_cnt_q;
         flush_cnt_o = flush_cnt_q;
         if (mem_stall_i) begin
            freeze_o     = 1'b1;
            stall_pc_o   = 1'b1;
            stall_ifid_o = 1'b1;
         end else if (redirect_i) begin
            flush_ifid_o = 1'b1;
            bubble_ex_o  = 1'b1;
         end else if (lu) begin
            stall_pc_o   = 1'b1;
            stall_ifid_o = 1'b1;
            bubble_ex_o  = 1'b1;
         end
         if (ex_u1_q && mem_we_q && (mem_rd_q == ex_rs1_q))     fwd_a_o = 2'b01;
         else if (ex_u1_q && wb_we_q && (wb_rd_q == ex_rs1_q))  fwd_a_o = 2'b10;
         if (ex_u2_q && mem_we_q && (mem_rd_q == ex_rs2_q))     fwd_b_o = 2'b01;
         else if (ex_u2_q && wb_we_q && (wb_rd_q == ex_rs2_q))  fwd_b_o = 2'b10;
      end
   end

   always_comb begin
      ex_rs1_d    = ex_rs1_q;
      ex_rs2_d    = ex_rs2_q;
      ex_u1_d     = ex_u1_q;
      ex_u2_d     = ex_u2_q;
      ex_rd_d     = ex_rd_q;
      ex_we_d     = ex_we_q;
      ex_ld_d     = ex_ld_q;
      mem_rd_d    = mem_rd_q;
      mem_we_d    = mem_we_q;
      wb_rd_d     = wb_rd_q;
      wb_we_d     = wb_we_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!mem_stall_i) begin
         wb_rd_d  = mem_rd_q;
         wb_we_d  = mem_we_q;
         mem_rd_d = ex_rd_q;
         mem_we_d = ex_we_q;
         if (redirect_i || lu) begin
            ex_rs1_d = 5'd0;
            ex_rs2_d = 5'd0;
            ex_u1_d  = 1'b0;
            ex_u2_d  = 1'b0;
            ex_rd_d  = 5'd0;
            ex_we_d  = 1'b0;
            ex_ld_d  = 1'b0;
         end else begin
            ex_rs1_d = id_rs1;
            ex_rs2_d = id_rs2;
            ex_u1_d  = id_u1;
            ex_u2_d  = id_u2;
            ex_rd_d  = id_rd;
            ex_we_d  = id_we;
            ex_ld_d  = id_ld;
         end
         if (redirect_i)  flush_cnt_d = flush_cnt_q + 32'd1;
         else if (lu)     stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_rs1_q    <= 5'd0;
         ex_rs2_q    <= 5'd0;
         ex_u1_q     <= 1'b0;
         ex_u2_q     <= 1'b0;
         ex_rd_q     <= 5'd0;
         ex_we_q     <= 1'b0;
         ex_ld_q     <= 1'b0;
         mem_rd_q    <= 5'd0;
         mem_we_q    <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_we_q     <= 1'b0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         ex_rs1_q    <= ex_rs1_d;
         ex_rs2_q    <= ex_rs2_d;
         ex_u1_q     <= ex_u1_d;
         ex_u2_q     <= ex_u2_d;
         ex_rd_q     <= ex_rd_d;
         ex_we_q     <= ex_we_d;
         ex_ld_q     <= ex_ld_d;
         mem_rd_q    <= mem_rd_d;
         mem_we_q    <= mem_we_d;
         wb_rd_q     <= wb_rd_d;
         wb_we_q     <= wb_we_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed expectations for each hazard scenario.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] id_instr_i;
   logic        id_valid_i, redirect_i, mem_stall_i;
   logic        stall_pc_o, stall_ifid_o, flush_ifid_o, bubble_ex_o, freeze_o;
   logic [1:0]  fwd_a_o, fwd_b_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;

   int checks = 0;
   int failures = 0;

   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_IM = 7'b0010011;
   localparam logic [6:0] OP_R  = 7'b0110011;

   hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_instr_i(id_instr_i), .id_valid_i(id_valid_i),
      .redirect_i(redirect_i), .mem_stall_i(mem_stall_i),
      .stall_pc_o(stall_pc_o), .stall_ifid_o(stall_ifid_o), .flush_ifid_o(flush_ifid_o),
      .bubble_ex_o(bubble_ex_o), .freeze_o(freeze_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, op};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic id(input logic [31:0] ins, input logic v);
      id_instr_i = ins;
      id_valid_i = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      id(32'd0, 1'b0);
      redirect_i  = 1'b0;
      mem_stall_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      settle();
   endtask

   // packs control outputs {stall_pc, stall_ifid, flush_ifid, bubble_ex, freeze}
   function automatic logic [31:0] ctl();
      return {27'd0, stall_pc_o, stall_ifid_o, flush_ifid_o, bubble_ex_o, freeze_o};
   endfunction

   logic [31:0] lw_x5, add_lu, lw_x0, add_x0, addi_x7, add_77, add_37;

   initial begin
      lw_x5   = enc(OP_LD, 5'd5, 5'd2, 5'd0);
      add_lu  = enc(OP_R, 5'd6, 5'd5, 5'd1);
      lw_x0   = enc(OP_LD, 5'd0, 5'd2, 5'd0);
      add_x0  = enc(OP_R, 5'd1, 5'd0, 5'd0);
      addi_x7 = enc(OP_IM, 5'd7, 5'd3, 5'd0);
      add_77  = enc(OP_R, 5'd8, 5'd7, 5'd7);
      add_37  = enc(OP_R, 5'd9, 5'd3, 5'd7);

      // reset state
      rst = 1'b1; id(add_lu, 1'b1); redirect_i = 1'b1; mem_stall_i = 1'b0;
      settle();
      check("rst_ctl", ctl(), 32'h0);
      do_reset();
      check("post_rst_ctl", ctl(), 32'h0);
      check("post_rst_cnt", stall_cnt_o | flush_cnt_o, 32'h0);

      // load-use on rs1
      id(lw_x5, 1'b1); settle();
      check("lu_no_stall_first", ctl(), 32'h0);
      step();
      id(add_lu, 1'b1); settle();
      check("lu_stall", ctl(), 32'b11010);
      step();
      check("lu_cleared", ctl(), 32'h0);
      check("lu_stall_cnt", stall_cnt_o, 32'd1);
      step();
      id(32'd0, 1'b0); settle();
      check("lu_fwd_a_wb", {30'd0, fwd_a_o}, 32'd2);
      check("lu_fwd_b", {30'd0, fwd_b_o}, 32'd0);

      // forward priority: MEM and WB both write x7
      do_reset();
      id(addi_x7, 1'b1); step();
      id(addi_x7, 1'b1); step();
      id(add_77, 1'b1); step();
      id(32'd0, 1'b0); settle();
      check("fwd_mem_a", {30'd0, fwd_a_o}, 32'd1);
      check("fwd_mem_b", {30'd0, fwd_b_o}, 32'd1);
      // only WB writes x7
      do_reset();
      id(addi_x7, 1'b1); step();
      id(32'd0, 1'b0); step();
      id(add_77, 1'b1); step();
      id(32'd0, 1'b0); settle();
      check("fwd_wb_a", {30'd0, fwd_a_o}, 32'd2);
      check("fwd_wb_b", {30'd0, fwd_b_o}, 32'd2);
      // only rs2 matches MEM
      do_reset();
      id(addi_x7, 1'b1); step();
      id(add_37, 1'b1); step();
      id(32'd0, 1'b0); settle();
      check("fwd_rs2_only_a", {30'd0, fwd_a_o}, 32'd0);
      check("fwd_rs2_only_b", {30'd0, fwd_b_o}, 32'd1);

      // x0 never hazards or forwards
      do_reset();
      id(lw_x0, 1'b1); step();
      id(add_x0, 1'b1); settle();
      check("x0_no_stall", ctl(), 32'h0);
      step();
      id(32'd0, 1'b0); settle();
      check("x0_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'd0);

      // redirect overrides a pending load-use
      do_reset();
      id(lw_x5, 1'b1); step();
      id(add_lu, 1'b1); redirect_i = 1'b1; settle();
      check("redir_ctl", ctl(), 32'b00110);
      step();
      redirect_i = 1'b0; settle();
      check("redir_flush_cnt", flush_cnt_o, 32'd1);
      check("redir_stall_cnt", stall_cnt_o, 32'd0);
      check("redir_after_ctl", ctl(), 32'h0);

      // memory stall for 3 cycles while a load-use is pending
      do_reset();
      id(lw_x5, 1'b1); step();
      id(add_lu, 1'b1); mem_stall_i = 1'b1; settle();
      check("frz1", ctl(), 32'b11001);
      step();
      redirect_i = 1'b1; settle();
      check("frz2_redir_masked", ctl(), 32'b11001);
      step();
      redirect_i = 1'b0; settle();
      check("frz3", ctl(), 32'b11001);
      step();
      mem_stall_i = 1'b0; settle();
      check("frz_cnts", {stall_cnt_o[15:0], flush_cnt_o[15:0]}, 32'd0);
      check("frz_then_lu", ctl(), 32'b11010);
      step();
      check("frz_lu_cnt", stall_cnt_o, 32'd1);
      check("frz_lu_done", ctl(), 32'h0);

      // reset during a load-use stall
      do_reset();
      id(lw_x5, 1'b1); step();
      id(add_lu, 1'b1); step();
      id(lw_x5, 1'b1); step();
      id(add_lu, 1'b1); settle();
      check("rms_pre_stall", ctl(), 32'b11010);
      check("rms_pre_cnt", stall_cnt_o, 32'd1);
      rst = 1'b1; settle();
      check("rms_ctl_now", ctl(), 32'h0);
      check("rms_cnt_now", stall_cnt_o, 32'd0);
      step();
      rst = 1'b0; settle();
      check("rms_after_ctl", ctl(), 32'h0);
      check("rms_after_cnt", stall_cnt_o | flush_cnt_o, 32'd0);
      check("rms_after_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
